clk_period_meter: RTL
=====================

# clk_period_meter

Measures the period and high time of a slow, asynchronous clock-like input such as the 1 Hz display tick, counting cycles of the fast system clock i_clk. It performs the inverse of a clock divider: a divider turns a cycle count into a clock, and this block turns a clock back into a cycle count. It sits on the digital-clock board as a self-check and calibration monitor for generated ticks. It reports one measurement per input period, with a valid pulse, plus lock and timeout status.

## Interface
- CNT_W, 32: width of the cycle counters and results; must hold TIMEOUT.
- TIMEOUT, 200000000: cycles without a rising edge before a timeout is declared (2 s at 100 MHz).
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_en  in  1  measurement enable, synchronous to i_clk.
- i_sig  in  1  signal under measurement, asynchronous to i_clk.
- o_period  out  CNT_W  i_clk cycles between consecutive rising edges of i_sig.
- o_high  out  CNT_W  i_clk cycles i_sig was high within that period.
- o_valid  out  1  single-cycle pulse when o_period/o_high update.
- o_locked  out  1  high after the first complete measurement since arming.
- o_timeout  out  1  level; high when no rising edge is seen for TIMEOUT cycles.

## Operation
- i_sig passes through a 2-flop synchronizer. Rise/fall pulses (rise, fall) come from comparing the synchronized value with its previous value.
- States:
  - IDLE: entered when i_en=0.
  - ARM: waits for the first rise.
  - MEAS: counts between rises.
- IDLE -> ARM when i_en=1. Entering IDLE clears cnt, hcnt and o_locked; o_period/o_high hold their last values.
- ARM:
  - cnt increments every cycle.
  - On rise: cnt<=1, hcnt<=1, go to MEAS. No o_valid.
- MEAS, each cycle:
  - cnt<=cnt+1.
  - hcnt increments while the synchronized i_sig is 1.
  - On fall: hcnt is copied to hold_high.
- MEAS on rise:
  - o_period<=cnt, o_high<=hold_high, o_valid=1 next cycle.
  - o_locked<=1, o_timeout<=0.
  - cnt<=1, hcnt<=1; stay in MEAS.
- Timeout applies in ARM or MEAS: cnt==TIMEOUT with no rise in that cycle sets o_timeout<=1, o_locked<=0, go to ARM with cnt<=0. o_timeout stays high until the next completed measurement.
- Rise on the same cycle as cnt==TIMEOUT: the rise wins and the measurement reports o_period=TIMEOUT.
- No fall within a period (duty 100% after sync): hold_high = value captured at the previous fall, or 0 if none. A fall is required for o_high to be meaningful.
- Counters saturate at 2^CNT_W-1; they never wrap.
- i_en low in any state: go to IDLE next cycle. An in-flight measurement is discarded and no o_valid is issued.

## Timing
- Reset values: o_period=0, o_high=0, o_valid=0, o_locked=0, o_timeout=0. State=IDLE, all counters 0.
- Latency from i_sig rising to o_valid: rise is asserted on the 3rd i_clk edge after i_sig changes (2 sync + 1 edge register); o_valid is asserted on the following edge.
- o_period/o_high change only in the cycle o_valid is high and are stable otherwise.
- An async reset mid-measurement returns everything to reset values immediately; the first o_valid after reset requires two rises.

## Structure
- Shared package clk_meas_pkg: state enum {IDLE, ARM, MEAS}, default CNT_W, and the TIMEOUT default for 100 MHz.
- Sub-module sync_edge_detect: i_clk, i_rst_n, async input; outputs o_level, o_rise, o_fall. It is reusable for button and tick inputs on the same board.
- Top module: FSM, cnt/hcnt/hold_high counters, output registers.

## Test plan
- TIMEOUT=50, i_en=1, i_sig period 10 high 4 -> first o_valid after the 2nd rise with o_period=10, o_high=4, o_locked=1. Each subsequent o_valid repeats the same values, exactly 10 cycles apart.
- i_sig period switches from 10/5 to 20/15 -> in-order reports 10/5 then 20/15, with no spurious o_valid.
- TIMEOUT=50, i_sig stops low after a rise -> o_timeout=1 and o_locked=0 exactly 50 cycles after the last rise was detected. Restarting at period 10 clears o_timeout on the first reported measurement.
- Period exactly 50 with TIMEOUT=50 -> o_valid with o_period=50 and o_timeout stays 0. Period 51 -> timeout, then re-arm.
- i_en dropped mid-period -> no o_valid, o_locked=0, o_period holds its last value. Re-enabling needs two rises before the next o_valid.
- i_rst_n asserted asynchronously mid-period -> all outputs 0 immediately. After release, the first o_valid requires two rises and reports the correct period.

Source files
------------

// File: rtl/clk_meas_pkg.sv
// clk_meas_pkg: shared FSM state type and default sizing for the clock period meter
package clk_meas_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } meas_state_e;
  localparam int unsigned DEF_CNT_W   = 32;
  localparam int unsigned DEF_TIMEOUT = 200_000_000;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: 2-flop synchronizer with registered rise/fall pulses
//   i_clk, i_rst_n : clock, async active-low reset
//   i_sig          : asynchronous input
//   o_level        : synchronized level, aligned with the pulses
//   o_rise, o_fall : one-cycle pulses in the first cycle o_level shows the new value
module sync_edge_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic [2:0] sh_q;
  logic       rise_q;
  logic       fall_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sh_q   <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sh_q   <= {sh_q[1:0], i_sig};
      rise_q <= sh_q[1] & ~sh_q[2];
      fall_q <= ~sh_q[1] & sh_q[2];
    end
  end
  assign o_level = sh_q[2];
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;
endmodule

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of a slow async signal in i_clk cycles
//   i_clk, i_rst_n : system clock, async active-low reset
//   i_en           : measurement enable
//   i_sig          : signal under measurement
//   o_period       : cycles between consecutive rises
//   o_high         : cycles high within that period
//   o_valid        : one-cycle pulse when o_period/o_high update
//   o_locked       : a complete measurement exists since arming
//   o_timeout      : no rise seen for TIMEOUT cycles
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_sig,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic             o_valid,
  output logic             o_locked,
  output logic             o_timeout
);
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  meas_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;
  logic             lvl, rise, fall;
  logic [CNT_W-1:0] cnt_inc, hcnt_inc;
  logic             expired;
  sync_edge_detect u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_sig   (i_sig),
    .o_level (lvl),
    .o_rise  (rise),
    .o_fall  (fall)
  );
  // saturating increments: counters stick at all-ones instead of wrapping
  assign cnt_inc  = &cnt_q  ? cnt_q  : cnt_q + ONE;
  assign hcnt_inc = &hcnt_q ? hcnt_q : hcnt_q + ONE;
  assign expired  = cnt_q == TO_CNT;
  // a rise always takes priority over expiry in the same cycle
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    hold_d    = hold_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    timeout_d = timeout_q;
    if (!i_en) begin
      state_d  = IDLE;
      cnt_d    = '0;
      hcnt_d   = '0;
      hold_d   = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = ARM;
        ARM: begin
          if (rise) begin
            state_d = MEAS;
            cnt_d   = ONE;
            hcnt_d  = ONE;
          end else if (expired) begin
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        MEAS: begin
          cnt_d  = cnt_inc;
          hcnt_d = lvl ? hcnt_inc : hcnt_q;
          if (fall) hold_d = hcnt_q;
          if (rise) begin
            period_d  = cnt_q;
            high_d    = hold_q;
            valid_d   = 1'b1;
            locked_d  = 1'b1;
            timeout_d = 1'b0;
            cnt_d     = ONE;
            hcnt_d    = ONE;
          end else if (expired) begin
            state_d   = ARM;
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            cnt_d     = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      hold_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      hold_q    <= hold_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end
  assign o_period  = period_q;
  assign o_high    = high_q;
  assign o_valid   = valid_q;
  assign o_locked  = locked_q;
  assign o_timeout = timeout_q;
endmodule
